// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0

    // Instruction-memory port sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing in flight
        REQ  = 2'd1,   // request raised, waiting for grant
        WAIT = 2'd2    // granted, waiting for rvalid
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps at 32 bits.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// One-entry {pc, instr} parking register for responses that arrive while F is stalled.
// Latency: push is visible on full_o/entry_o the cycle after it is accepted.
// Backpressure: owner must not push while full; clear beats push, push beats pop.
module fetch_holdbuf
    import fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t entry_i,
    output logic         full_o,
    output fetch_entry_t entry_o
);

    logic         full_q, full_d;
    fetch_entry_t entry_q, entry_d;

    // Next-state: clear (redirect) discards anything parked, even a same-cycle push.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d  = 1'b1;
            entry_d = entry_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full_o  = full_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a single-outstanding req/gnt/rvalid imem port, registers F.
// Latency: zero-wait memory gives one instruction every 2 cycles; F loads the edge after rvalid.
// Backpressure: F_stall/PC_stall hold F and the PC; a response landing during a stall is parked.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        PC_stall_i,
    input  logic        F_stall_i,
    input  logic        F_bubble_i,
    input  logic        E_jmp_sel_i,
    input  logic [31:0] E_jmp_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        F_valid_o,
    output logic [31:0] F_pc_o,
    output logic [31:0] F_instr_o
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;          // next address to fetch
    logic [31:0] addr_q, addr_d;      // address presented while in REQ, frozen until grant
    logic [31:0] req_pc_q, req_pc_d;  // address of the request currently in WAIT
    logic        drop_q, drop_d;      // in-flight response is stale
    logic        pend_q, pend_d;      // redirect hit while REQ was ungranted: stale at grant

    logic        f_valid_q, f_valid_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] f_instr_q, f_instr_d;

    logic         redirect;
    logic         f_adv;
    logic         gnt;
    logic         rsp;
    logic         rsp_acc;
    logic         can_start;
    logic         hb_push;
    logic         hb_pop;
    logic         hb_full;
    fetch_entry_t hb_in;
    fetch_entry_t hb_out;

    // A jump select without the matching bubble is not a redirect.
    assign redirect  = E_jmp_sel_i & F_bubble_i;
    assign f_adv     = ~F_stall_i & ~F_bubble_i;
    assign gnt       = (state_q == REQ)  & imem_gnt_i;
    assign rsp       = (state_q == WAIT) & imem_rvalid_i;
    // A response is kept only if it is not stale and not killed by a same-cycle redirect.
    assign rsp_acc   = rsp & ~drop_q & ~redirect;
    assign hb_push   = rsp_acc & ~f_adv;
    assign hb_pop    = hb_full & f_adv;
    // Only start a new fetch when nothing is, or is about to be, parked.
    assign can_start = ~PC_stall_i & ~hb_full & ~hb_push & ~redirect;
    assign hb_in     = '{pc: req_pc_q, instr: imem_rdata_i};

    fetch_holdbuf u_holdbuf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (hb_push),
        .pop_i   (hb_pop),
        .clear_i (redirect),
        .entry_i (hb_in),
        .full_o  (hb_full),
        .entry_o (hb_out)
    );

    // FSM next state; WAIT chains straight into REQ so zero-wait memory streams at 1 per 2 cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_start)     state_d = REQ;
            REQ:     if (imem_gnt_i)    state_d = WAIT;
            WAIT:    if (imem_rvalid_i) state_d = can_start ? REQ : IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, request address and stale-response tracking.
    always_comb begin
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        pend_d   = pend_q;

        if (gnt) begin
            req_pc_d = addr_q;
            pend_d   = 1'b0;
            // After a deferred redirect pc_q already holds the target.
            if (!pend_q) pc_d = next_pc(pc_q);
        end
        // Redirect target overrides any same-cycle increment.
        if (redirect) pc_d = E_jmp_pc_i;
        // Ungranted request must still complete at its old address; mark it stale for later.
        if (redirect && (state_q == REQ) && !imem_gnt_i) pend_d = 1'b1;

        if (rsp) drop_d = 1'b0;
        if (gnt && (pend_q || redirect)) drop_d = 1'b1;
        // A response coinciding with the redirect is discarded directly, so no flag then.
        if (redirect && (state_q == WAIT) && !imem_rvalid_i) drop_d = 1'b1;

        // Freeze the presented address on entry to REQ.
        if ((state_q != REQ) && (state_d == REQ)) addr_d = pc_q;
    end

    // PC-side registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            pend_q   <= pend_d;
        end
    end

    // F-stage update: bubble, then stall, then parked entry, then live response, else NOP.
    always_comb begin
        f_valid_d = f_valid_q;
        f_pc_d    = f_pc_q;
        f_instr_d = f_instr_q;
        if (F_bubble_i) begin
            f_valid_d = 1'b0;
            f_instr_d = NOP;
        end else if (!F_stall_i) begin
            if (hb_full) begin
                f_valid_d = 1'b1;
                f_pc_d    = hb_out.pc;
                f_instr_d = hb_out.instr;
            end else if (rsp_acc) begin
                f_valid_d = 1'b1;
                f_pc_d    = req_pc_q;
                f_instr_d = imem_rdata_i;
            end else begin
                f_valid_d = 1'b0;
                f_instr_d = NOP;
            end
        end
    end

    // F-stage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_valid_q <= 1'b0;
            f_pc_q    <= 32'd0;
            f_instr_q <= NOP;
        end else begin
            f_valid_q <= f_valid_d;
            f_pc_q    <= f_pc_d;
            f_instr_q <= f_instr_d;
        end
    end

    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = addr_q;
    assign F_valid_o   = f_valid_q;
    assign F_pc_o      = f_pc_q;
    assign F_instr_o   = f_instr_q;

endmodule
